// File: rtl/program_loader.sv
// UART boot loader: receives a framed, XOR-checked program over rx and writes it
// word by word into the CPU instruction memory while holding the CPU.
module program_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned MAX_WORDS    = 256,
  parameter int unsigned GAP_BITS     = 16
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        rx,
  output logic        memWriteEn,
  output logic [15:0] memWriteAddr,
  output logic [15:0] memWriteData,
  output logic        cpuHold,
  output logic        done,
  output logic        error,
  output logic [15:0] wordCount
);

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] MaxWords = 16'(MAX_WORDS);
  localparam logic [31:0] GapLimit = 32'(GAP_BITS * CLKS_PER_BIT);
  localparam logic [7:0]  SyncByte = 8'hA5;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StDataHi, StDataLo, StCheck, StError
  } ld_state_e;

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e   rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  rx_shift_q;
  logic        byte_valid_q, frame_err_q;

  ld_state_e   ld_state_q;
  logic [15:0] len_q, count_q;
  logic [7:0]  hi_q, chk_q;
  logic [31:0] gap_q;
  logic        wr_en_q, hold_q, done_q, error_q;
  logic [15:0] wr_addr_q, wr_data_q;

  logic [15:0] new_len, count_next;
  logic        active;

  assign new_len    = {len_q[15:8], rx_shift_q};
  assign count_next = count_q + 16'd1;
  assign active     = (ld_state_q != StIdle) && (ld_state_q != StError);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // 8N1 receiver; all sampling points are timed from the start-bit midpoint.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_state_q   <= RxIdle;
      rx_cnt_q     <= '0;
      bit_idx_q    <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_q   <= '0;
            bit_idx_q  <= '0;
            rx_state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RxData: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            bit_idx_q  <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) rx_state_q <= RxStop;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RxStop: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RxIdle;
            if (rx_sync_q) byte_valid_q <= 1'b1;
            else           frame_err_q  <= 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ld_state_q <= StIdle;
      len_q      <= '0;
      count_q    <= '0;
      hi_q       <= '0;
      chk_q      <= '0;
      gap_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (!active || byte_valid_q) gap_q <= '0;
      else                         gap_q <= gap_q + 32'd1;

      if (byte_valid_q) begin
        unique case (ld_state_q)
          StIdle, StError: begin
            // 0xA5 only resynchronises here; mid-frame it is ordinary data.
            if (rx_shift_q == SyncByte) begin
              ld_state_q <= StLenHi;
              hold_q     <= 1'b1;
              error_q    <= 1'b0;
              count_q    <= '0;
              chk_q      <= '0;
            end
          end
          StLenHi: begin
            len_q[15:8] <= rx_shift_q;
            ld_state_q  <= StLenLo;
          end
          StLenLo: begin
            len_q[7:0] <= rx_shift_q;
            if (new_len == 16'd0 || new_len > MaxWords) begin
              ld_state_q <= StError;
              error_q    <= 1'b1;
            end else begin
              ld_state_q <= StDataHi;
            end
          end
          StDataHi: begin
            hi_q       <= rx_shift_q;
            chk_q      <= chk_q ^ rx_shift_q;
            ld_state_q <= StDataLo;
          end
          StDataLo: begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= count_q;
            wr_data_q  <= {hi_q, rx_shift_q};
            count_q    <= count_next;
            chk_q      <= chk_q ^ rx_shift_q;
            ld_state_q <= (count_next == len_q) ? StCheck : StDataHi;
          end
          StCheck: begin
            if (rx_shift_q == chk_q) begin
              done_q     <= 1'b1;
              hold_q     <= 1'b0;
              ld_state_q <= StIdle;
            end else begin
              error_q    <= 1'b1;
              ld_state_q <= StError;
            end
          end
          default: ld_state_q <= StIdle;
        endcase
      end else if (active && (frame_err_q || gap_q > GapLimit)) begin
        error_q    <= 1'b1;
        ld_state_q <= StError;
      end
    end
  end

  assign memWriteEn   = wr_en_q;
  assign memWriteAddr = wr_addr_q;
  assign memWriteData = wr_data_q;
  assign cpuHold      = hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign wordCount    = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: drives UART frames on rx and scoreboards the memory writes.
module tb_program_loader;

  localparam int unsigned Cpb = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic        rx;
  logic        memWriteEn;
  logic [15:0] memWriteAddr;
  logic [15:0] memWriteData;
  logic        cpuHold;
  logic        done;
  logic        error;
  logic [15:0] wordCount;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned done_cnt = 0;
  int unsigned d0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  logic [7:0]  tx_q[$];

  always #5 clk = ~clk;

  program_loader #(
    .CLKS_PER_BIT(Cpb),
    .MAX_WORDS   (256),
    .GAP_BITS    (16)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .rx          (rx),
    .memWriteEn  (memWriteEn),
    .memWriteAddr(memWriteAddr),
    .memWriteData(memWriteData),
    .cpuHold     (cpuHold),
    .done        (done),
    .error       (error),
    .wordCount   (wordCount)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected {addr,data}.
  always @(negedge clk) begin
    if (memWriteEn) begin
      if (exp_q.size() == 0) begin
        check_val("unexp_wr", 32'(memWriteEn), 32'd0);
      end else begin
        exp_w = exp_q.pop_front();
        check_val("wr_addr", 32'(memWriteAddr), 32'(exp_w[31:16]));
        check_val("wr_data", 32'(memWriteData), 32'(exp_w[15:0]));
      end
    end
    if (done) done_cnt++;
  end

  task automatic push_wr(input logic [15:0] addr, input logic [15:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic idle_bits(input int n);
    repeat (n * Cpb) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rx = stop_bit;
    repeat (Cpb) @(negedge clk);
    rx = 1'b1;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_all();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_we"},    32'(memWriteEn),   32'd0);
    check_val({tag, "_addr"},  32'(memWriteAddr), 32'd0);
    check_val({tag, "_data"},  32'(memWriteData), 32'd0);
    check_val({tag, "_hold"},  32'(cpuHold),      32'd0);
    check_val({tag, "_done"},  32'(done),         32'd0);
    check_val({tag, "_error"}, 32'(error),        32'd0);
    check_val({tag, "_wc"},    32'(wordCount),    32'd0);
  endtask

  task automatic check_good(input string tag, input int unsigned words);
    repeat (5) @(negedge clk);
    check_val({tag, "_done"},  32'(done_cnt - d0), 32'd1);
    check_val({tag, "_hold"},  32'(cpuHold),       32'd0);
    check_val({tag, "_error"}, 32'(error),         32'd0);
    check_val({tag, "_wc"},    32'(wordCount),     32'(words));
    check_val({tag, "_pend"},  32'(exp_q.size()),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    rx   = 1'b1;
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rstN = 1'b1;
    idle_bits(2);

    // Good two-word frame
    d0 = done_cnt;
    push_wr(16'd0, 16'h1234);
    push_wr(16'd1, 16'hABCD);
    tx_q = '{8'hA5};
    send_all();
    check_val("t1_hold_busy", 32'(cpuHold), 32'd1);
    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_all();
    check_good("t1", 2);

    // Bad checksum, then correct resend
    d0 = done_cnt;
    push_wr(16'd0, 16'h1234);
    push_wr(16'd1, 16'hABCD);
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_all();
    repeat (5) @(negedge clk);
    check_val("t2_nodone", 32'(done_cnt - d0), 32'd0);
    check_val("t2_error",  32'(error),         32'd1);
    check_val("t2_hold",   32'(cpuHold),       32'd1);
    check_val("t2_pend",   32'(exp_q.size()),  32'd0);
    d0 = done_cnt;
    push_wr(16'd0, 16'h1234);
    push_wr(16'd1, 16'hABCD);
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_all();
    check_good("t2r", 2);

    // Length above MAX_WORDS
    tx_q = '{8'hA5, 8'h01, 8'h01};
    send_all();
    repeat (5) @(negedge clk);
    check_val("t3_error", 32'(error),     32'd1);
    check_val("t3_hold",  32'(cpuHold),   32'd1);
    check_val("t3_wc",    32'(wordCount), 32'd0);

    // Half-bit glitch and junk byte ignored; 0xA5 inside data is data
    @(negedge clk);
    rx = 1'b0;
    repeat (Cpb / 2) @(negedge clk);
    rx = 1'b1;
    idle_bits(2);
    send_byte(8'h3C, 1'b1);
    d0 = done_cnt;
    push_wr(16'd0, 16'hA55A);
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'h5A, 8'hFF};
    send_all();
    check_good("t4", 1);

    // Inter-byte gap timeout
    tx_q = '{8'hA5, 8'h00, 8'h03};
    send_all();
    check_val("t5_err_clr", 32'(error), 32'd0);
    idle_bits(17);
    check_val("t5_gap_err",  32'(error),   32'd1);
    check_val("t5_gap_hold", 32'(cpuHold), 32'd1);

    // Framing error on a data byte
    tx_q = '{8'hA5, 8'h00, 8'h01};
    send_all();
    check_val("t6_err_clr", 32'(error), 32'd0);
    send_byte(8'h12, 1'b0);
    repeat (5) @(negedge clk);
    check_val("t6_frm_err", 32'(error),     32'd1);
    check_val("t6_wc",      32'(wordCount), 32'd0);

    // Asynchronous reset mid-frame, then a normal load
    push_wr(16'd0, 16'h1234);
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_all();
    repeat (3) @(negedge clk);
    check_val("t7_pre_hold", 32'(cpuHold),      32'd1);
    check_val("t7_pre_wc",   32'(wordCount),    32'd1);
    check_val("t7_pend",     32'(exp_q.size()), 32'd0);
    #2 rstN = 1'b0;
    #1 check_reset("t7_arst");
    @(negedge clk);
    rstN = 1'b1;
    idle_bits(2);
    d0 = done_cnt;
    push_wr(16'd0, 16'h1234);
    push_wr(16'd1, 16'hABCD);
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_all();
    check_good("t7", 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
